div32x32: RTL

- 32-bit by 32-bit iterative unsigned integer divider; the inverse of the team's iterative 32x32 multiplier.
- Uses the same start/busy handshake so both units share one issue slot in the arithmetic datapath.
- Restoring division, BITS_PER_CYCLE quotient bits produced per clock.
- Produces quotient, remainder and a divide-by-zero flag.

---
 rtl/div32x32.sv | 104 ++++++++++
 1 files changed

// File: rtl/div32x32.sv
// div32x32: iterative restoring 32/32 unsigned divider, BITS_PER_CYCLE quotient bits per clock; define DIV32X32_SIGNED_EN for signed_op support
module div32x32 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef DIV32X32_SIGNED_EN
    input  logic        signed_op,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    localparam logic [5:0] N = 6'(32 / BITS_PER_CYCLE);
    typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_busy, r_dbz, r_neg_q, r_neg_r;
    logic [31:0] r_dvd, r_dvs, r_quot, r_rem;
    logic [5:0]  r_cnt;
    logic        w_sgn, w_accept, w_last, w_busy_nxt;
    logic [31:0] w_a_mag, w_b_mag, w_dvd_nxt, w_quot_nxt, w_rem_nxt, w_quot_fin, w_rem_fin;
    logic [32:0] w_sh, w_diff;
`ifdef DIV32X32_SIGNED_EN
    assign w_sgn = signed_op;
`else
    assign w_sgn = 1'b0;
`endif
    assign w_accept    = r_state == IDLE && start;
    assign w_last      = r_cnt == 6'd1;
    assign w_a_mag     = w_sgn && a[31] ? -a : a;
    assign w_b_mag     = w_sgn && b[31] ? -b : b;
    assign w_quot_fin  = r_neg_q ? -w_quot_nxt : w_quot_nxt;
    assign w_rem_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign busy        = r_busy;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;

    always_comb
        w_state_nxt = r_state == IDLE ? (start ? (b == '0 ? ZERO : CALC) : IDLE) :
                      r_state == CALC ? (w_last ? IDLE : CALC) : IDLE;

    always_comb
        w_busy_nxt = w_state_nxt != IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_busy <= 1'b0;
        else       r_busy <= w_busy_nxt;

    // the 33-bit shifted remainder makes the trial subtract's borrow the sign bit
    always_comb begin
        w_rem_nxt  = r_rem;
        w_quot_nxt = r_quot;
        w_dvd_nxt  = r_dvd;
        w_sh       = '0;
        w_diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sh       = {w_rem_nxt, w_dvd_nxt[31]};
            w_diff     = w_sh - {1'b0, r_dvs};
            w_dvd_nxt  = w_dvd_nxt << 1;
            w_rem_nxt  = w_diff[32] ? w_sh[31:0] : w_diff[31:0];
            w_quot_nxt = {w_quot_nxt[30:0], ~w_diff[32]};
        end
    end

    // divide-by-zero keeps the raw dividend so the remainder reports a unchanged
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_dvd   <= b == '0 ? a : w_a_mag;
            r_dvs   <= w_b_mag;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_cnt   <= N;
            r_neg_q <= w_sgn && (a[31] ^ b[31]);
            r_neg_r <= w_sgn && a[31];
        end else if (r_state == CALC) begin
            r_dvd  <= w_dvd_nxt;
            r_cnt  <= r_cnt - 6'd1;
            r_quot <= w_last ? w_quot_fin : w_quot_nxt;
            r_rem  <= w_last ? w_rem_fin : w_rem_nxt;
        end else if (r_state == ZERO) begin
            r_quot <= '1;
            r_rem  <= r_dvd;
            r_dbz  <= 1'b1;
        end
endmodule
